// File: rtl/key_debounce_sched.sv
// Key debouncer: shared sample prescaler, per-key 4-state debounce FSM, and a round-robin
// arbiter that merges accepted presses into one valid/ready event stream.
module key_debounce_sched #(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned PRESCALE     = 262144,
    parameter int unsigned STABLE_TICKS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         sw,
    output logic [NUM_KEYS-1:0]         db_level,
    output logic [NUM_KEYS-1:0]         db_tick,
    output logic                        evt_valid,
    output logic [$clog2(NUM_KEYS)-1:0] evt_id,
    input  logic                        evt_ready,
    output logic                        evt_overflow
);

    localparam int unsigned IdW  = $clog2(NUM_KEYS);
    localparam int unsigned PreW = $clog2(PRESCALE);
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
    localparam logic [3:0]      CntLast = 4'(STABLE_TICKS - 1);
    localparam logic [IdW-1:0]  IdLast  = IdW'(NUM_KEYS - 1);

    typedef enum logic [1:0] {StIdle, StDelay0, StOne, StDelay1} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sw_s_q;
    logic [PreW-1:0]     pre_cnt_q, pre_cnt_d;
    logic                tick;

    state_e     state_q [NUM_KEYS];
    state_e     state_d [NUM_KEYS];
    logic [3:0] cnt_q   [NUM_KEYS];
    logic [3:0] cnt_d   [NUM_KEYS];

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] db_level_q, db_level_d, db_tick_q;
    logic [NUM_KEYS-1:0] pending_q, pending_d, clr, cand;
    logic                evt_valid_q, evt_valid_d, ovf_q, ovf_d, handshake, found;
    logic [IdW-1:0]      evt_id_q, evt_id_d, last_grant_q, last_grant_d, nxt_id, idx;

    assign tick      = (pre_cnt_q == PreLast);
    assign pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                StIdle: begin
                    if (sw_s_q[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = StDelay0;
                    end
                end
                StDelay0: begin
                    if (!sw_s_q[i]) begin
                        state_d[i] = StIdle;
                    end else if (tick) begin
                        if (cnt_q[i] == CntLast) begin
                            state_d[i] = StOne;
                            press[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                end
                StOne: begin
                    if (!sw_s_q[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = StDelay1;
                    end
                end
                StDelay1: begin
                    if (sw_s_q[i]) begin
                        state_d[i] = StOne;
                    end else if (tick) begin
                        if (cnt_q[i] == CntLast) begin
                            state_d[i] = StIdle;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                end
                default: state_d[i] = StIdle;
            endcase
            db_level_d[i] = (state_d[i] == StOne) || (state_d[i] == StDelay1);
        end
    end

    always_comb begin
        handshake = evt_valid_q & evt_ready;
        clr       = '0;
        if (handshake) begin
            clr[evt_id_q] = 1'b1;
        end
        // The key just granted is masked out so a coincident re-press waits its turn.
        cand         = pending_q & ~clr;
        pending_d    = press | cand;
        ovf_d        = ovf_q | (|(press & pending_q & ~clr));
        last_grant_d = handshake ? evt_id_q : last_grant_q;

        found  = 1'b0;
        nxt_id = evt_id_q;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_KEYS; k++) begin
            idx = IdW'((32'(last_grant_d) + k) % NUM_KEYS);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                nxt_id = idx;
            end
        end

        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        if (!evt_valid_q || handshake) begin
            evt_valid_d = found;
            evt_id_d    = nxt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sw_s_q       <= '0;
            pre_cnt_q    <= '0;
            db_level_q   <= '0;
            db_tick_q    <= '0;
            pending_q    <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= IdLast;
            ovf_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q      <= sw;
            sw_s_q       <= sync1_q;
            pre_cnt_q    <= pre_cnt_d;
            db_level_q   <= db_level_d;
            db_tick_q    <= press;
            pending_q    <= pending_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign db_level     = db_level_q;
    assign db_tick      = db_tick_q;
    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_id_q;
    assign evt_overflow = ovf_q;

endmodule
